pipe_hazard_sb: RTL
===================

# pipe_hazard_sb

Parametrised hazard and interlock unit for the five-stage pipeline (IF, ID, EXE, MEM, WB). It sits beside the ID-stage decoder and keeps its own shadow copy of the EXE and MEM destination state. From that state it generates operand-forwarding selects, load-use stalls, and structural stalls for a multi-cycle multiplier that occupies EXE. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_W, 5, register index width (2^REG_W architectural registers).
- MUL_LAT, 3, multiplier EXE occupancy in cycles; legal range 1 to 15. A value of 1 means single-cycle.
- R0_ZERO, 1, when 1, register index 0 never creates a dependency.
- CNT_W, 16, stall counter width.

Ports (clock and reset first):
- clock, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-high; clears all state.
- id_valid, in, 1, ID holds a real instruction.
- id_rs, id_rt, in, REG_W, source register indices.
- id_use_rs, id_use_rt, in, 1, instruction reads rs / rt.
- id_rn, in, REG_W, destination register index.
- id_wreg, in, 1, instruction writes id_rn.
- id_m2reg, in, 1, instruction is a load.
- id_mul, in, 1, instruction uses the multi-cycle multiplier.
- id_flush, in, 1, squash the ID instruction (taken branch or jump).
- cnt_clr, in, 1, synchronous clear of stall_count.
- stall, out, 1, hold PC and the IF/ID register.
- issue, out, 1, the ID instruction enters EXE this cycle.
- fwda, fwdb, out, 2, operand A / B source: 00 = register file, 01 = EXE ALU result, 10 = MEM ALU result, 11 = MEM load data.
- mul_busy, out, 1, multiplier holding EXE.
- stall_count, out, CNT_W, stall cycles seen, saturating.

## Operation
- State: EXE slot {e_valid, e_rn, e_wreg, e_m2reg}; MEM slot {m_valid, m_rn, m_wreg, m_m2reg}; 4-bit mul_cnt; stall_count.
- Dependency terms:
  - dep_e_x = id_use_x & e_valid & e_wreg & (e_rn == id_x) & ~(R0_ZERO & id_x == 0).
  - dep_m_x is the same test against the MEM slot.
- Forwarding select, per operand: if dep_e_x & ~e_m2reg, select 01. Otherwise, if dep_m_x, select 11 when m_m2reg and 10 when not. Otherwise select 00. The EXE match has priority over the MEM match, so the youngest producer wins.
- load_stall = id_valid & ~id_flush & e_m2reg & (dep_e_a | dep_e_b).
- mul_busy = (mul_cnt != 0).
- stall = load_stall | mul_busy.
- issue = id_valid & ~id_flush & ~stall.
- Update when mul_busy is high:
  - EXE slot holds.
  - MEM slot loads a bubble (m_valid = 0).
  - mul_cnt decrements.
- Update otherwise:
  - MEM slot takes the EXE slot.
  - EXE slot takes the ID fields if issue is high; otherwise it loads a bubble.
  - If issue & id_mul & MUL_LAT > 1, mul_cnt is set to MUL_LAT-1.
- Flushed or stalled ID instructions never enter EXE. id_flush asserted while mul_busy is a protocol violation (EXE holds a multiply, not a branch). In that case it affects only issue, which is already 0.
- stall_count: cnt_clr has priority and clears it. Otherwise it increments each cycle stall is high and saturates at all-ones.

## Timing
- stall, issue, fwda, fwdb and mul_busy are combinational from current state and ID inputs, valid in the same cycle.
- Reset values: all slots invalid, mul_cnt = 0, stall_count = 0. Therefore stall = 0, mul_busy = 0, fwda = fwdb = 00, and issue = id_valid & ~id_flush.
- Reset asserted mid-multiply clears mul_cnt immediately (asynchronously). Any in-flight instruction is discarded.
- Load-use costs exactly 1 stall cycle. On the next cycle the load is in MEM and the consumer gets select 11.
- A multiply issued at edge N holds EXE for MUL_LAT cycles. stall is high for cycles N+1 through N+MUL_LAT-1. A dependent instruction issues in cycle N+MUL_LAT with select 01.
- A back-to-back multiply is allowed once mul_busy drops.

## Test plan
- Forwarding: add r3 issued, then sub r4 ← r3, r3 → at the sub, fwda = fwdb = 01, stall = 0. One cycle later, an instruction reading r3 gets select 10.
- Load-use: lw r5, then add r6 ← r5, r1 → one cycle of stall = 1 and issue = 0. Next cycle fwda = 11, issue = 1, and stall_count = 1.
- R0 and priority: a write to r0 followed by a reader of r0 → fwda = 00 with R0_ZERO = 1. With producers of r7 in both EXE and MEM, the reader gets 01.
- Multiply, MUL_LAT = 3: mul r8 issued, then a dependent add → mul_busy and stall are high for 2 cycles, a bubble reaches MEM each of those cycles, then the add issues with select 01. Repeat with MUL_LAT = 1 → no stall.
- Flush: id_flush during a load-use hazard → stall = 0 and issue = 0, and the EXE slot becomes a bubble on the next cycle.
- Reset and counter: assert reset during cycle 1 of a multiply → mul_busy = 0 immediately, with no clock edge. Separately, with CNT_W = 2, hold the multiplier stall for 5 cycles → stall_count saturates at 3; cnt_clr then returns it to 0.

Source files
------------

// File: rtl/pipe_hazard_sb.sv
// pipe_hazard_sb: hazard and interlock unit beside the ID-stage decoder.
// Keeps a shadow copy of the EXE/MEM destination state and from it derives
// operand-forwarding selects, load-use stalls, multiplier structural stalls
// and a saturating stall-cycle counter.
module pipe_hazard_sb #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 3,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_mul,
  input  logic             id_flush,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             issue,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic       MUL_MULTI = (MUL_LAT > 1);
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_MULTI ? MUL_LAT - 1 : 0);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rn;
    logic             wreg;
    logic             m2reg;
  } slot_t;

  slot_t            e_q, e_d;
  slot_t            m_q, m_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic dep_e_a, dep_e_b, dep_m_a, dep_m_b;
  logic load_stall;

  // A source matches a slot only if the slot really writes that register;
  // register 0 is hard-wired and never forwarded when R0_ZERO is set.
  function automatic logic dep(input logic use_src, input logic [REG_W-1:0] src,
                               input slot_t s);
    return use_src & s.valid & s.wreg & (s.rn == src) &
           ~((R0_ZERO != 0) && (src == '0));
  endfunction

  // EXE ALU result wins over anything in MEM; a load still in EXE cannot be
  // forwarded, so it falls through to the MEM check (and load_stall covers it).
  function automatic logic [1:0] fwd_sel(input logic de, input logic dm);
    if (de && !e_q.m2reg) return FWD_EXE;
    else if (dm)          return m_q.m2reg ? FWD_LD : FWD_MEM;
    else                  return FWD_RF;
  endfunction

  // Hazard detection and forwarding selects, combinational from state and ID.
  always_comb begin
    dep_e_a    = dep(id_use_rs, id_rs, e_q);
    dep_e_b    = dep(id_use_rt, id_rt, e_q);
    dep_m_a    = dep(id_use_rs, id_rs, m_q);
    dep_m_b    = dep(id_use_rt, id_rt, m_q);
    fwda       = fwd_sel(dep_e_a, dep_m_a);
    fwdb       = fwd_sel(dep_e_b, dep_m_b);
    load_stall = id_valid & ~id_flush & e_q.m2reg & (dep_e_a | dep_e_b);
    mul_busy   = (mul_cnt_q != 4'd0);
    stall      = load_stall | mul_busy;
    issue      = id_valid & ~id_flush & ~stall;
  end

  // Next-state for the shadow pipeline slots and the multiplier occupancy.
  always_comb begin
    e_d       = e_q;
    m_d       = m_q;
    mul_cnt_d = mul_cnt_q;
    if (mul_busy) begin
      m_d       = '0;
      mul_cnt_d = mul_cnt_q - 4'd1;
    end else begin
      m_d = e_q;
      if (issue) begin
        e_d.valid = 1'b1;
        e_d.rn    = id_rn;
        e_d.wreg  = id_wreg;
        e_d.m2reg = id_m2reg;
        if (id_mul && MUL_MULTI) mul_cnt_d = MUL_LOAD;
      end else begin
        e_d = '0;
      end
    end
  end

  // Slot and multiplier state registers; reset discards in-flight work.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_q       <= '0;
      m_q       <= '0;
      mul_cnt_q <= 4'd0;
    end else begin
      e_q       <= e_d;
      m_q       <= m_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Saturating stall-cycle counter; clear wins over counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (stall && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = stall_cnt_q;

endmodule
